// File: rtl/stream_demux_1_to_2_pkg.sv
// Shared constants, defaults and FIFO occupancy states for the 1-to-2 stream demux.
package stream_demux_1_to_2_pkg;

    // Select encodings carried on in_sel with each beat
    localparam logic DEMUX_SEL_P0 = 1'b0;
    localparam logic DEMUX_SEL_P1 = 1'b1;

    // Default geometry of the unit
    localparam int DEMUX_WIDTH = 4;
    localparam int DEMUX_DEPTH = 2;
    localparam int DEMUX_CNTW  = 8;

    // Occupancy class of one destination FIFO
    typedef enum logic [1:0] {
        FIFO_EMPTY   = 2'd0,
        FIFO_PARTIAL = 2'd1,
        FIFO_FULL    = 2'd2
    } fifo_state_e;

    // Maps an entry count onto its occupancy class
    function automatic fifo_state_e fifo_state_of(input int level, input int depth);
        if (level == 0) begin
            return FIFO_EMPTY;
        end else if (level >= depth) begin
            return FIFO_FULL;
        end else begin
            return FIFO_PARTIAL;
        end
    endfunction

endpackage

// File: rtl/stream_demux_1_to_2_if.sv
// Handshake bundle between the producer, the demux and its two consumers.
interface stream_demux_1_to_2_if
    import stream_demux_1_to_2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int CNTW  = DEMUX_CNTW
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_sel;

    logic             out0_valid;
    logic             out0_ready;
    logic [WIDTH-1:0] out0_data;

    logic             out1_valid;
    logic             out1_ready;
    logic [WIDTH-1:0] out1_data;

    logic [CNTW-1:0]  cnt0;
    logic [CNTW-1:0]  cnt1;

    // Environment side: producer and both consumers
    modport master (
        output in_valid, in_data, in_sel, out0_ready, out1_ready,
        input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

    // Demux side
    modport slave (
        input  in_valid, in_data, in_sel, out0_ready, out1_ready,
        output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
    );

endinterface

// File: rtl/stream_demux_1_to_2_port_fifo.sv
// DEPTH-entry synchronous FIFO for one destination port. Occupancy is tracked
// as a count plus an EMPTY/PARTIAL/FULL state; full/empty come straight from
// registered state so nothing downstream sees a same-cycle pass-through.
module stream_demux_1_to_2_port_fifo
    import stream_demux_1_to_2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    fifo_state_e      state_q;
    fifo_state_e      state_d;
    logic             do_push;
    logic             do_pop;

    // Requests that would overflow or underflow are ignored here as a backstop
    assign do_push = push && (state_q != FIFO_FULL);
    assign do_pop  = pop  && (state_q != FIFO_EMPTY);

    // Occupancy count and state register
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            state_q <= FIFO_EMPTY;
        end else begin
            count_q <= count_d;
            state_q <= state_d;
        end
    end

    // Next occupancy: push moves up, pop moves down, push+pop holds
    always_comb begin
        count_d = count_q;
        state_d = state_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        state_d = fifo_state_of(int'(count_d), DEPTH);
    end

    // Storage and pointers; storage is cleared so an untouched head reads zero
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    assign head_data = mem[rd_ptr];
    assign full      = (state_q == FIFO_FULL);
    assign empty     = (state_q == FIFO_EMPTY);

endmodule

// File: rtl/stream_demux_1_to_2.sv
// Buffered 1-to-2 steering unit. Each beat goes to the FIFO named by its
// select bit; each port drains independently and counts delivered beats.
module stream_demux_1_to_2
    import stream_demux_1_to_2_pkg::*;
#(
    parameter int WIDTH = DEMUX_WIDTH,
    parameter int DEPTH = DEMUX_DEPTH,
    parameter int CNTW  = DEMUX_CNTW
) (
    input  logic                  clk,
    input  logic                  rst,
    stream_demux_1_to_2_if.slave  bus
);

    logic             in_ready_w;
    logic             accept;
    logic             push0;
    logic             push1;
    logic             pop0;
    logic             pop1;
    logic             full0;
    logic             full1;
    logic             empty0;
    logic             empty1;
    logic [WIDTH-1:0] head0;
    logic [WIDTH-1:0] head1;
    logic [CNTW-1:0]  cnt0_q;
    logic [CNTW-1:0]  cnt1_q;

    // Ready depends only on the registered fullness of the selected port, so a
    // pop on a full port this cycle does not open the input until next cycle.
    assign in_ready_w = (bus.in_sel == DEMUX_SEL_P1) ? !full1 : !full0;
    assign accept     = bus.in_valid && in_ready_w;

    // in_sel only matters when a beat is actually accepted
    assign push0 = accept && (bus.in_sel == DEMUX_SEL_P0);
    assign push1 = accept && (bus.in_sel == DEMUX_SEL_P1);

    assign pop0 = !empty0 && bus.out0_ready;
    assign pop1 = !empty1 && bus.out1_ready;

    stream_demux_1_to_2_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo0 (
        .clk       (clk),
        .rst       (rst),
        .push      (push0),
        .push_data (bus.in_data),
        .pop       (pop0),
        .head_data (head0),
        .full      (full0),
        .empty     (empty0)
    );

    stream_demux_1_to_2_port_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo1 (
        .clk       (clk),
        .rst       (rst),
        .push      (push1),
        .push_data (bus.in_data),
        .pop       (pop1),
        .head_data (head1),
        .full      (full1),
        .empty     (empty1)
    );

    // Delivered-beat counters, wrapping freely at 2^CNTW
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (pop0) begin
                cnt0_q <= cnt0_q + CNTW'(1);
            end
            if (pop1) begin
                cnt1_q <= cnt1_q + CNTW'(1);
            end
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out0_valid = !empty0;
    assign bus.out0_data  = head0;
    assign bus.out1_valid = !empty1;
    assign bus.out1_data  = head1;
    assign bus.cnt0       = cnt0_q;
    assign bus.cnt1       = cnt1_q;

endmodule

// File: tb/tb_stream_demux_1_to_2.sv
// Self-checking bench for stream_demux_1_to_2: directed scenarios followed by
// a random phase, all compared against a queue-based model of the two ports.
module tb_stream_demux_1_to_2;
    import stream_demux_1_to_2_pkg::*;

    localparam int WIDTH = 4;
    localparam int DEPTH = 2;
    localparam int CNTW  = 8;

    logic clk = 1'b0;
    logic rst;

    stream_demux_1_to_2_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

    stream_demux_1_to_2 #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNTW  (CNTW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one queue per port in acceptance order, delivered counts
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];
    int               m_cnt0;
    int               m_cnt1;
    bit               written0;
    bit               written1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("out0_valid", 32'(bus.out0_valid), 32'(q0.size() != 0));
        check("out1_valid", 32'(bus.out1_valid), 32'(q1.size() != 0));
        if (q0.size() != 0)   check("out0_data", 32'(bus.out0_data), 32'(q0[0]));
        else if (!written0)   check("out0_data_clear", 32'(bus.out0_data), 32'd0);
        if (q1.size() != 0)   check("out1_data", 32'(bus.out1_data), 32'(q1[0]));
        else if (!written1)   check("out1_data_clear", 32'(bus.out1_data), 32'd0);
        check("cnt0", 32'(bus.cnt0), 32'(m_cnt0));
        check("cnt1", 32'(bus.cnt1), 32'(m_cnt1));
    endtask

    // One clock of stimulus: check state, drive inputs, check ready, update model
    task automatic apply_stimulus(input logic v, input logic s, input logic [WIDTH-1:0] d,
                                  input logic r0, input logic r1);
        bit exp_rdy;
        bit acc;
        bit p0;
        bit p1;
        @(negedge clk);
        check_output();
        bus.in_valid   = v;
        bus.in_sel     = s;
        bus.in_data    = d;
        bus.out0_ready = r0;
        bus.out1_ready = r1;
        #1;
        exp_rdy = (s ? q1.size() : q0.size()) != DEPTH;
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        p0  = r0 && (q0.size() != 0);
        p1  = r1 && (q1.size() != 0);
        @(posedge clk);
        if (p0) begin
            void'(q0.pop_front());
            m_cnt0 = (m_cnt0 + 1) % (1 << CNTW);
        end
        if (p1) begin
            void'(q1.pop_front());
            m_cnt1 = (m_cnt1 + 1) % (1 << CNTW);
        end
        if (acc) begin
            if (s) begin
                q1.push_back(d);
                written1 = 1'b1;
            end else begin
                q0.push_back(d);
                written0 = 1'b1;
            end
        end
    endtask

    // Hold rst for n edges with a live producer and ready consumers
    task automatic do_reset(input int n);
        logic [31:0] rnd;
        @(negedge clk);
        rnd            = $urandom;
        rst            = 1'b1;
        bus.in_valid   = 1'b1;
        bus.in_sel     = rnd[4];
        bus.in_data    = rnd[WIDTH-1:0];
        bus.out0_ready = 1'b1;
        bus.out1_ready = 1'b1;
        repeat (n) @(posedge clk);
        q0.delete();
        q1.delete();
        m_cnt0   = 0;
        m_cnt1   = 0;
        written0 = 1'b0;
        written1 = 1'b0;
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        #1;
        check_output();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] rnd;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_sel     = 1'b0;
        bus.in_data    = '0;
        bus.out0_ready = 1'b0;
        bus.out1_ready = 1'b0;
        m_cnt0         = 0;
        m_cnt1         = 0;
        written0       = 1'b0;
        written1       = 1'b0;

        $display("[TB] reset with producer active");
        do_reset(2);

        $display("[TB] steering");
        apply_stimulus(1'b1, 1'b0, 4'h9, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b1, 4'h8, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        #1;
        check("steer_cnt0", 32'(bus.cnt0), 32'd1);
        check("steer_cnt1", 32'(bus.cnt1), 32'd1);

        $display("[TB] backpressure isolation");
        apply_stimulus(1'b1, 1'b0, 4'h1, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 4'h2, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b0, 4'h3, 1'b0, 1'b1);
        apply_stimulus(1'b1, 1'b1, 4'hA, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
        #1;
        check("bp_cnt1", 32'(bus.cnt1), 32'd2);
        check("bp_port0_held", 32'(bus.out0_valid), 32'd1);

        $display("[TB] full port with same-cycle pop");
        apply_stimulus(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 4'h3, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        #1;
        check("full_cnt0", 32'(bus.cnt0), 32'd4);

        $display("[TB] counter wrap on port 1");
        do_reset(1);
        for (int i = 0; i < 256; i++) begin
            rnd = $urandom;
            apply_stimulus(1'b1, 1'b1, rnd[WIDTH-1:0], 1'b0, 1'b1);
        end
        apply_stimulus(1'b0, 1'b1, 4'h0, 1'b0, 1'b1);
        #1;
        check("wrap_cnt1", 32'(bus.cnt1), 32'd0);
        check("wrap_cnt0", 32'(bus.cnt0), 32'd0);
        check("wrap_drained", 32'(bus.out1_valid), 32'd0);

        $display("[TB] mid-stream reset");
        apply_stimulus(1'b1, 1'b0, 4'hC, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'hD, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'hE, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'hF, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 4'h7, 1'b1, 1'b1);
        apply_stimulus(1'b1, 1'b0, 4'h7, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 4'h6, 1'b0, 1'b0);
        do_reset(1);
        apply_stimulus(1'b1, 1'b0, 4'h5, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        #1;
        check("post_rst_cnt0", 32'(bus.cnt0), 32'd1);
        check("post_rst_cnt1", 32'(bus.cnt1), 32'd0);

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            rnd = $urandom;
            apply_stimulus(rnd[0], rnd[1], rnd[7:4], (rnd[10:8] != 3'd0), (rnd[13:11] > 3'd2));
        end
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);
        apply_stimulus(1'b0, 1'b0, 4'h0, 1'b1, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
